// File: rtl/dmem_write_buffer_if.sv
// dmem_write_buffer_if
// Memory-side bus of the data-memory store buffer.
//   mem_waddr/mem_wdata/mem_wbe : oldest buffered store (word address, data, lane enables)
//   mem_wvalid / mem_wready     : write handshake, transfer when both are high at a rising edge
//   mem_raddr / mem_rdata       : asynchronous load port, data returned in the same cycle
// master = write buffer, slave = memory.
interface dmem_write_buffer_if;
  logic [29:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wbe;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [29:0] mem_raddr;
  logic [31:0] mem_rdata;

  modport master (
    output mem_waddr, mem_wdata, mem_wbe, mem_wvalid, mem_raddr,
    input  mem_wready, mem_rdata
  );

  modport slave (
    input  mem_waddr, mem_wdata, mem_wbe, mem_wvalid, mem_raddr,
    output mem_wready, mem_rdata
  );
endinterface

// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer
// Circular store buffer between the core and data memory. Stores are queued
// and drained to memory in order; loads read memory directly unless they hit
// a buffered store, in which case they either forward or stall.
// Parameter DEPTH : number of entries (power of two, 2..16).
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   MemWrite, MemRead     : core store / load request (store wins if both)
//   ALUResult             : byte address, word address = ALUResult[31:2]
//   WriteData, ByteEn     : store data (lane aligned) and lane enables
//   ReadData, Stall       : combinational load data and core hold request
//   count                 : number of buffered entries
//   mem                   : memory-side bus (dmem_write_buffer_if.master)
// Build option: define DMEM_WBUF_FWD_EN to forward full-word stores to hitting
// loads; otherwise any hitting load stalls until the matching entries drain.
module dmem_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic                     MemRead,
  input  logic [31:0]              ALUResult,
  input  logic [31:0]              WriteData,
  input  logic [3:0]               ByteEn,
  output logic [31:0]              ReadData,
  output logic                     Stall,
  output logic [$clog2(DEPTH):0]   count,
  dmem_write_buffer_if.master      mem
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic [29:0]   addr_r [DEPTH];
  logic [31:0]   data_r [DEPTH];
  logic [3:0]    be_r   [DEPTH];

  logic [29:0]   word_s;
  logic [PW-1:0] slot_s;
  logic          hit_s;
  logic          load_s;
  logic          full_s;
  logic          fwd_ok_s;
  logic          enq_s;
  logic          deq_s;
  logic          unused_s;
`ifdef DMEM_WBUF_FWD_EN
  logic [PW-1:0] newest_s;
`endif

  assign word_s   = ALUResult[31:2];
  assign unused_s = ^ALUResult[1:0];

  // Address match against valid entries; walking from oldest to newest
  // leaves the newest matching slot in newest_s.
  always_comb begin
    hit_s  = 1'b0;
    slot_s = rd_ptr_r;
`ifdef DMEM_WBUF_FWD_EN
    newest_s = rd_ptr_r;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      slot_s = rd_ptr_r + PW'(k);
      if ((CW'(k) < count_r) && (addr_r[slot_s] == word_s)) begin
        hit_s = 1'b1;
`ifdef DMEM_WBUF_FWD_EN
        newest_s = slot_s;
`endif
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Stall, load data and FIFO push/pop decisions for this cycle.
  always_comb begin
    load_s   = MemRead & ~MemWrite;
    full_s   = (count_r == CW'(DEPTH));
    ReadData = mem.mem_rdata;
`ifdef DMEM_WBUF_FWD_EN
    fwd_ok_s = (be_r[newest_s] == 4'b1111);
    if (load_s && hit_s && fwd_ok_s) begin
      ReadData = data_r[newest_s];
    end else begin
      ReadData = mem.mem_rdata;
    end
`else
    fwd_ok_s = 1'b0;
`endif
    // A full buffer refuses a store even when a drain frees a slot this edge.
    Stall = (MemWrite & full_s) | (load_s & hit_s & ~fwd_ok_s);
    enq_s = MemWrite & ~full_s;
    deq_s = (count_r != {CW{1'b0}}) & mem.mem_wready;
  end

  // Pointer and occupancy state; reset empties the buffer at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (enq_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (deq_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; validity is tracked by pointers and count only.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      addr_r[wr_ptr_r] <= word_s;
      data_r[wr_ptr_r] <= WriteData;
      be_r[wr_ptr_r]   <= ByteEn;
    end
  end

  assign mem.mem_wvalid = (count_r != {CW{1'b0}});
  assign mem.mem_waddr  = addr_r[rd_ptr_r];
  assign mem.mem_wdata  = data_r[rd_ptr_r];
  assign mem.mem_wbe    = be_r[rd_ptr_r];
  assign mem.mem_raddr  = word_s;
  assign count          = count_r;

endmodule

// File: tb/tb_dmem_write_buffer.sv
module tb_dmem_write_buffer;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic          MemWrite;
  logic          MemRead;
  logic [31:0]   ALUResult;
  logic [31:0]   WriteData;
  logic [3:0]    ByteEn;
  logic [31:0]   ReadData;
  logic          Stall;
  logic [CW-1:0] count;

  int checks = 0;
  int failures = 0;

  // Memory contents as seen by the environment, indexed by word address[7:0].
  logic [31:0] mem_arr [256];

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;
  ent_t q[$];

  dmem_write_buffer_if mif();

  dmem_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ByteEn    (ByteEn),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .count     (count),
    .mem       (mif)
  );

  assign mif.mem_rdata = mem_arr[ALUResult[9:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  // One core cycle: drive, check against the queue model, advance model and clock.
  task automatic cyc(input logic we, input logic re, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be, input logic wr);
    bit full, hit, fwd;
    int nw;
    logic exp_stall;
    logic [31:0] exp_rd;
    MemWrite = we; MemRead = re; ALUResult = a; WriteData = d; ByteEn = be;
    mif.mem_wready = wr;
    #2;
    full = (q.size() == DEPTH);
    hit = 1'b0;
    nw = 0;
    foreach (q[i]) begin
      if (q[i].a == a[31:2]) begin hit = 1'b1; nw = i; end
    end
`ifdef DMEM_WBUF_FWD_EN
    fwd = hit && (q[nw].be == 4'hF);
`else
    fwd = 1'b0;
`endif
    exp_stall = (we && full) || (re && !we && hit && !fwd);
    chk("stall", 32'(Stall), 32'(exp_stall));
    chk("count", 32'(count), 32'(q.size()));
    chk("wvalid", 32'(mif.mem_wvalid), 32'(q.size() != 0));
    chk("raddr", 32'(mif.mem_raddr), 32'(a[31:2]));
    if (q.size() != 0) begin
      chk("waddr", 32'(mif.mem_waddr), 32'(q[0].a));
      chk("wdata", mif.mem_wdata, q[0].d);
      chk("wbe", 32'(mif.mem_wbe), 32'(q[0].be));
    end
    if (!we && !exp_stall) begin
      exp_rd = (re && fwd) ? q[nw].d : mem_arr[a[9:2]];
      chk("rdata", ReadData, exp_rd);
    end
    if (wr && q.size() != 0) begin
      mem_arr[q[0].a[7:0]] = merge(mem_arr[q[0].a[7:0]], q[0].d, q[0].be);
      void'(q.pop_front());
    end
    if (we && !full) q.push_back('{a[31:2], d, be});
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra;
    int op;
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'(i) * 32'h01010101;
    mem_arr[8'h80] = 32'h0;
    reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; ALUResult = 32'h0;
    WriteData = 32'h0; ByteEn = 4'h0; mif.mem_wready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_wvalid", 32'(mif.mem_wvalid), 32'h0);
    MemWrite = 1'b1;
    #1;
    chk("rst_stall", 32'(Stall), 32'h0);
    MemWrite = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Fill with memory stalled, fifth store refused, then in-order drain.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h100 + 32'(4*i), 32'hA0 + 32'(i), 4'hF, 1'b0);
    cyc(1'b1, 1'b0, 32'h110, 32'h5A5A5A5A, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("order", 32'(mif.mem_waddr), 32'h40 + 32'(i));
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    end
    chk("drained", 32'(count), 32'h0);

    // Full-word store followed by a load of the same word.
    cyc(1'b1, 1'b0, 32'h200, 32'hDEADBEEF, 4'hF, 1'b0);
    cyc(1'b0, 1'b1, 32'h200, 32'h0, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h200, 32'h0, 4'h0, 1'b1);
    MemWrite = 1'b0; MemRead = 1'b1; ALUResult = 32'h200;
    #1;
    chk("load_after_drain", ReadData, 32'hDEADBEEF);
    chk("load_after_drain_stall", 32'(Stall), 32'h0);
    cyc(1'b0, 1'b1, 32'h200, 32'h0, 4'h0, 1'b0);

    // Two stores to one word: newest wins.
    cyc(1'b1, 1'b0, 32'h300, 32'h11111111, 4'hF, 1'b0);
    cyc(1'b1, 1'b0, 32'h300, 32'h22222222, 4'hF, 1'b0);
    cyc(1'b0, 1'b1, 32'h300, 32'h0, 4'h0, 1'b0);
    repeat (2) cyc(1'b0, 1'b1, 32'h300, 32'h0, 4'h0, 1'b1);
    cyc(1'b0, 1'b1, 32'h300, 32'h0, 4'h0, 1'b0);

    // Partial-lane store blocks a hitting load until it drains.
    cyc(1'b1, 1'b0, 32'h400, 32'h000000AB, 4'b0001, 1'b0);
    cyc(1'b0, 1'b1, 32'h400, 32'h0, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h400, 32'h0, 4'h0, 1'b1);
    cyc(1'b0, 1'b1, 32'h403, 32'h0, 4'h0, 1'b0);

    // Full with a simultaneous drain, then pointer wrap over 3*DEPTH stores.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 32'h500 + 32'(4*i), $urandom, 4'hF, 1'b0);
    cyc(1'b1, 1'b0, 32'h600, 32'h66666666, 4'hF, 1'b1);
    chk("full_drain_count", 32'(count), 32'(DEPTH - 1));
    cyc(1'b1, 1'b0, 32'h600, 32'h66666666, 4'hF, 1'b0);
    for (int i = 0; i < 3*DEPTH; i++) cyc(1'b1, 1'b0, 32'h700 + 32'(4*i), $urandom, 4'hF, 1'b1);
    repeat (DEPTH + 1) cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);

    // Random traffic over a few words so hits, forwards and stalls mix.
    repeat (300) begin
      op = $urandom_range(0, 3);
      ra = 32'($urandom_range(0, 7)) * 32'd4 + 32'($urandom_range(0, 3));
      cyc(op[0], op[1], ra, $urandom,
          ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(1, 15)),
          ($urandom_range(0, 2) != 0));
    end
    repeat (DEPTH + 1) cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);

    // Reset in the middle of a pending drain.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h800 + 32'(4*i), 32'hC0 + 32'(i), 4'hF, 1'b0);
    MemWrite = 1'b0; MemRead = 1'b0; mif.mem_wready = 1'b0;
    #2;
    chk("pre_rst_count", 32'(count), 32'h3);
    chk("pre_rst_wvalid", 32'(mif.mem_wvalid), 32'h1);
    reset = 1'b1;
    #1;
    chk("async_rst_wvalid", 32'(mif.mem_wvalid), 32'h0);
    chk("async_rst_count", 32'(count), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    repeat (4) cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
